fp_multiplier: RTL and testbench

- Iterative IEEE-754 single-precision multiplier. It is the inverse-operation companion to the FP divider and sits beside it in the CPU's floating-point unit.
- Uses the same run/stall handshake and the same 25-cycle stall latency as the divider, so the CPU stall logic treats both units identically.
- Computes the mantissa product by shift-and-add, one bit per cycle. Results are truncated (no rounding), with no denormals, NaN or Inf handling beyond the rules below.

---
 rtl/fp_multiplier_pkg.sv | 35 +++
 rtl/fp_multiplier.sv | 42 ++++
 tb/tb_fp_multiplier.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fp_multiplier_pkg.sv
// Shared single-precision FP constants, field slices and result packing
// used by both the iterative multiplier and the divider.
package fp_multiplier_pkg;

  localparam int MW = 24;
  localparam int EB = 127;
  localparam logic [4:0] LAST = 5'd25;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int FRAC_HI  = 22;

  // Normalise the 48-bit mantissa product, apply the exponent range rules, pack.
  function automatic logic [31:0] fp_pack(input logic       sgn,
                                          input logic [7:0] xe,
                                          input logic [7:0] ye,
                                          input logic [47:0] prod);
    logic [9:0]  e1;
    logic [22:0] m;
    logic [31:0] r;
    e1 = {2'b00, xe} + {2'b00, ye} - 10'(EB) + {9'b0, prod[47]};
    m  = prod[47] ? prod[46:24] : prod[45:23];
    if (xe == 8'd0 || ye == 8'd0)
      r = 32'h0;
    else if ($signed(e1) >= 10'sd255)
      r = {sgn, 8'hFF, 23'h0};
    else if ($signed(e1) <= 10'sd0)
      r = 32'h0;
    else
      r = {sgn, e1[7:0], m};
    return r;
  endfunction

endpackage

// File: rtl/fp_multiplier.sv
// Iterative shift-and-add IEEE single multiplier, truncating; stall held 25 cycles after run.
// No internal buffering: caller holds run and operands until stall drops, then drops run.
module fp_multiplier
  import fp_multiplier_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        stall,
  output logic [31:0] z
);

  logic [4:0]  s;
  logic [47:0] p;
  logic [47:0] p_src;
  logic [24:0] w0;
  logic [24:0] w1;

  always_comb begin
    p_src = (s == 5'd0) ? {24'b0, 1'b1, x[FRAC_HI:0]} : p;
    w0    = p_src[0] ? {2'b01, y[FRAC_HI:0]} : 25'd0;
    w1    = {1'b0, p_src[47:24]} + w0;
  end

  // One multiplier bit is consumed per step at s=0..MW-1; P holds afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s <= 5'd0;
      p <= 48'd0;
    end else begin
      s <= run ? s + 5'd1 : 5'd0;
      if (s < 5'(MW))
        p <= {w1, p_src[23:1]};
    end
  end

  assign stall = run & (s != LAST);
  assign z     = fp_pack(x[SIGN_BIT] ^ y[SIGN_BIT], x[EXP_HI:EXP_LO], y[EXP_HI:EXP_LO], p);

endmodule

// File: tb/tb_fp_multiplier.sv
// Scoreboarded directed test of fp_multiplier: expected product and stall length queued per op.
module tb_fp_multiplier;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] x;
  logic [31:0] y;
  logic        stall;
  logic [31:0] z;

  typedef struct {
    string       name;
    logic [31:0] z;
  } exp_t;

  exp_t q[$];
  int   ntot = 0;
  int   nbad = 0;
  int   stall_cnt = 0;

  fp_multiplier dut (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .x    (x),
    .y    (y),
    .stall(stall),
    .z    (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: sample on the falling edge, compare on every valid cycle.
  always @(negedge clk) begin
    if (!rst || !run) begin
      stall_cnt = 0;
    end else if (stall) begin
      stall_cnt = stall_cnt + 1;
    end else begin
      if (q.size() == 0) begin
        ntot++; nbad++;
        $display("FAIL unexpected_valid z=%08h with empty scoreboard", z);
      end else begin
        exp_t e;
        e = q.pop_front();
        ntot++;
        if (z !== e.z) begin
          nbad++;
          $display("FAIL %s z: got %08h want %08h", e.name, z, e.z);
        end
        ntot++;
        if (stall_cnt != 25) begin
          nbad++;
          $display("FAIL %s stall_cycles: got %0d want 25", e.name, stall_cnt);
        end
      end
    end
  end

  task automatic do_op(input string name, input logic [31:0] xa, input logic [31:0] ya,
                       input logic [31:0] ze);
    exp_t e;
    bit   got;
    e.name = name;
    e.z    = ze;
    q.push_back(e);
    x   = xa;
    y   = ya;
    run = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!stall) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      ntot++; nbad++;
      $display("FAIL %s timeout: stall still %0b after 60 cycles, want 0", name, stall);
      void'(q.pop_back());
    end
    @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    run = 1'b0;
    x   = 32'h0;
    y   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    ntot++;
    if (dut.s !== 5'd0 || dut.p !== 48'd0) begin
      nbad++;
      $display("FAIL reset_state: s=%0d p=%012h want s=0 p=0", dut.s, dut.p);
    end
    ntot++;
    if (stall !== 1'b0) begin
      nbad++;
      $display("FAIL reset_stall: got %0b want 0", stall);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    do_op("mul_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000);
    do_op("neg_operand", 32'hC0200000, 32'h40800000, 32'hC1200000);
    do_op("one_x_one",   32'h3F800000, 32'h3F800000, 32'h3F800000);
    do_op("norm_p47",    32'h3FC00000, 32'h3FC00000, 32'h40100000);
    do_op("truncation",  32'h3F800001, 32'h3F800001, 32'h3F800002);
    do_op("x_zero",      32'h00000000, 32'h40400000, 32'h00000000);
    do_op("overflow",    32'h7F000000, 32'h7F000000, 32'h7F800000);
    do_op("ovf_neg",     32'hFF000000, 32'h7F000000, 32'hFF800000);
    do_op("e1_255",      32'h7F000000, 32'h40000000, 32'h7F800000);
    do_op("e1_254",      32'h7F000000, 32'h3F800000, 32'h7F000000);
    do_op("underflow",   32'h00800000, 32'h00800000, 32'h00000000);
    do_op("e1_0",        32'h3F000000, 32'h00800000, 32'h00000000);
    do_op("e1_1",        32'h3F800000, 32'h00800000, 32'h00800000);
    do_op("neg_x_zero",  32'hBF800000, 32'h00000000, 32'h00000000);

    // Abort at S=10, then a fresh operation must see a full-length stall.
    x   = 32'h3FC00000;
    y   = 32'h3FC00000;
    run = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    run = 1'b0;
    @(posedge clk); #1;
    do_op("after_abort", 32'h40000000, 32'h40000000, 32'h40800000);

    // Asynchronous reset mid-operation, off the clock edge.
    x   = 32'h40400000;
    y   = 32'h40400000;
    run = 1'b1;
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    ntot++;
    if (dut.s !== 5'd0) begin
      nbad++;
      $display("FAIL async_rst_s: got %0d want 0", dut.s);
    end
    ntot++;
    if (dut.p !== 48'd0) begin
      nbad++;
      $display("FAIL async_rst_p: got %012h want 0", dut.p);
    end
    run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_op("after_reset", 32'h3FC00000, 32'h40000000, 32'h40400000);

    repeat (3) @(posedge clk);
    ntot++;
    if (q.size() != 0) begin
      nbad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
